// File: rtl/icache_line_responder_if.sv
// -----------------------------------------------------------------------------
// icache_line_responder_if
//
// Bundles the two sides of the instruction-cache line-fill responder:
//   L1 miss side : L1_ADDR / L1_ADDR_VALID in, L1_DATA / L1_DATA_VALID out
//   Memory side  : MEM_ADDR / MEM_REQ out, MEM_RDATA / MEM_ACK in
//   Status       : BUSY, OVERRUN
//
// Modports:
//   slave  - the responder itself (drives L1_DATA*, MEM_ADDR/REQ, status)
//   master - the environment (L1 cache + memory) that talks to the responder
// -----------------------------------------------------------------------------
interface icache_line_responder_if #(
    parameter int data_width    = 32,
    parameter int address_width = 32,
    parameter int block_size    = 32
);
    localparam int offset_width = $clog2(data_width * block_size / 8);
    localparam int line_width   = data_width * block_size;

    logic [address_width-offset_width-1:0] L1_ADDR;
    logic                                  L1_ADDR_VALID;
    logic [line_width-1:0]                 L1_DATA;
    logic                                  L1_DATA_VALID;
    logic [address_width-1:0]              MEM_ADDR;
    logic                                  MEM_REQ;
    logic [data_width-1:0]                 MEM_RDATA;
    logic                                  MEM_ACK;
    logic                                  BUSY;
    logic                                  OVERRUN;

    modport slave (
        input  L1_ADDR, L1_ADDR_VALID, MEM_RDATA, MEM_ACK,
        output L1_DATA, L1_DATA_VALID, MEM_ADDR, MEM_REQ, BUSY, OVERRUN
    );

    modport master (
        output L1_ADDR, L1_ADDR_VALID, MEM_RDATA, MEM_ACK,
        input  L1_DATA, L1_DATA_VALID, MEM_ADDR, MEM_REQ, BUSY, OVERRUN
    );
endinterface

// File: rtl/icache_line_responder.sv
// -----------------------------------------------------------------------------
// icache_line_responder
//
// Serves L1 instruction-cache misses: takes a line address, reads the line one
// word at a time (ascending order) over a word-wide memory read port, assembles
// it in a private line buffer and returns the whole line with a one-cycle
// valid pulse. One extra request can be parked in a pending slot; anything
// beyond that is dropped and flagged on the sticky OVERRUN output.
//
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous, active-high reset
//   bus  - icache_line_responder_if.slave
//            L1_ADDR/L1_ADDR_VALID   line request (no back-pressure)
//            L1_DATA/L1_DATA_VALID   completed line + one-cycle pulse
//            MEM_ADDR/MEM_REQ        word read request, held until MEM_ACK
//            MEM_RDATA/MEM_ACK       word read data / completion
//            BUSY                    fill in progress or request pending
//            OVERRUN                 sticky, a request was dropped
// -----------------------------------------------------------------------------
module icache_line_responder #(
    parameter int data_width    = 32,
    parameter int address_width = 32,
    parameter int block_size    = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    icache_line_responder_if.slave  bus
);
    localparam int offset_width    = $clog2(data_width * block_size / 8);
    localparam int word_sel_width  = $clog2(block_size);
    localparam int line_width      = data_width * block_size;
    localparam int byte_sel_width  = $clog2(data_width / 8);
    localparam int line_addr_width = address_width - offset_width;

    localparam logic [word_sel_width-1:0] last_word = word_sel_width'(block_size - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } state_t;

    state_t                      state;
    logic [line_addr_width-1:0]  cur_line;
    logic [line_addr_width-1:0]  pending;
    logic                        pending_valid;
    logic [word_sel_width-1:0]   wcnt;
    logic [line_width-1:0]       line_buf;
    logic [line_width-1:0]       line_next;

    logic [line_width-1:0]       l1_data;
    logic                        l1_data_valid;
    logic [address_width-1:0]    mem_addr;
    logic                        mem_req;
    logic                        busy;
    logic                        overrun;

    // Word byte address is pure concatenation: line, word index, zero byte lane.
    function automatic logic [address_width-1:0] word_addr(
        input logic [line_addr_width-1:0] line,
        input logic [word_sel_width-1:0]  w
    );
        return {line, w, {byte_sel_width{1'b0}}};
    endfunction

    // Line buffer with the word being acknowledged this cycle merged in; the
    // output register copies this on the last word so the returned line
    // already contains the final word.
    always_comb begin
        line_next = line_buf;
        line_next[wcnt*data_width +: data_width] = bus.MEM_RDATA;
    end

    // Fill FSM. All outputs are registered here so they change only on CLK.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            cur_line      <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            wcnt          <= '0;
            line_buf      <= '0;
            l1_data       <= '0;
            l1_data_valid <= 1'b0;
            mem_addr      <= '0;
            mem_req       <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            l1_data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.L1_ADDR_VALID) begin
                        cur_line <= bus.L1_ADDR;
                        wcnt     <= '0;
                        mem_addr <= word_addr(bus.L1_ADDR, '0);
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end

                FETCH: begin
                    if (bus.L1_ADDR_VALID) begin
                        if (!pending_valid) begin
                            pending       <= bus.L1_ADDR;
                            pending_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                    if (bus.MEM_ACK) begin
                        line_buf <= line_next;
                        if (wcnt == last_word) begin
                            l1_data       <= line_next;
                            l1_data_valid <= 1'b1;
                            mem_req       <= 1'b0;
                            state         <= DONE;
                        end else begin
                            wcnt     <= wcnt + word_sel_width'(1);
                            mem_addr <= word_addr(cur_line, wcnt + word_sel_width'(1));
                        end
                    end
                end

                DONE: begin
                    // The parked request always goes first; a new request
                    // arriving now only fits if nothing was parked.
                    if (pending_valid) begin
                        cur_line      <= pending;
                        pending       <= '0;
                        pending_valid <= 1'b0;
                        wcnt          <= '0;
                        mem_addr      <= word_addr(pending, '0);
                        mem_req       <= 1'b1;
                        state         <= FETCH;
                        if (bus.L1_ADDR_VALID) begin
                            overrun <= 1'b1;
                        end
                    end else if (bus.L1_ADDR_VALID) begin
                        cur_line <= bus.L1_ADDR;
                        wcnt     <= '0;
                        mem_addr <= word_addr(bus.L1_ADDR, '0);
                        mem_req  <= 1'b1;
                        state    <= FETCH;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.L1_DATA       = l1_data;
    assign bus.L1_DATA_VALID = l1_data_valid;
    assign bus.MEM_ADDR      = mem_addr;
    assign bus.MEM_REQ       = mem_req;
    assign bus.BUSY          = busy;
    assign bus.OVERRUN       = overrun;

endmodule

// File: tb/tb_icache_line_responder.sv
// -----------------------------------------------------------------------------
// tb_icache_line_responder
//
// Drives icache_line_responder with directed and random line requests and a
// memory model whose read data is (byte address ^ salt). A reference model
// tracks accepted lines as a queue: a request is accepted while fewer than two
// lines are outstanding (the one being filled/returned plus one parked),
// otherwise it is dropped and OVERRUN is expected. Every cycle the bench
// compares MEM_REQ, MEM_ADDR, BUSY, OVERRUN, L1_DATA_VALID and L1_DATA against
// that model; the directed steps add latency and boundary checks.
// -----------------------------------------------------------------------------
module tb_icache_line_responder;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BS = 32;
    localparam int LW = DW * BS;

    logic CLK;
    logic RST;

    icache_line_responder_if #(.data_width(DW), .address_width(AW), .block_size(BS)) bus ();

    icache_line_responder #(
        .data_width   (DW),
        .address_width(AW),
        .block_size   (BS)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Memory model and ack pattern control
    logic [31:0] salt = 32'h0;
    int          ack_mode = 0;
    int          wait_phase = 0;
    assign bus.MEM_RDATA = bus.MEM_ADDR ^ salt;

    // Reference model state
    logic [24:0]   exp_lines[$];
    int            k = 0;
    logic          exp_valid = 1'b0;
    logic          exp_overrun = 1'b0;
    logic [LW-1:0] last_line = '0;
    logic [LW-1:0] exp_line;
    logic          mon_exp_req;
    logic          mon_next_valid;
    int            valid_cyc[$];
    int            req_cyc;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
        end
    end

    function automatic logic [31:0] tb_addr(input logic [24:0] l, input int w);
        return 32'(l) * 32'd128 + 32'(w) * 32'd4;
    endfunction

    function automatic logic [LW-1:0] model_line(input logic [24:0] l);
        logic [LW-1:0] r;
        r = '0;
        for (int w = 0; w < BS; w++) r[w*DW +: DW] = tb_addr(l, w) ^ salt;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        int widx;
        total++;
        assert (obs === exp) else begin
            bad++;
            widx = 0;
            for (int w = BS - 1; w >= 0; w--) if (obs[w*DW +: DW] !== exp[w*DW +: DW]) widx = w;
            $error("[TB] FAIL %s: word %0d got %h expected %h", tag, widx,
                   obs[widx*DW +: DW], exp[widx*DW +: DW]);
        end
    endtask

    task automatic applyStimulus(input logic [24:0] a);
        @(posedge CLK);
        #1;
        bus.L1_ADDR       = a;
        bus.L1_ADDR_VALID = 1'b1;
        req_cyc           = cyc;
        @(posedge CLK);
        #1;
        bus.L1_ADDR_VALID = 1'b0;
    endtask

    task automatic waitValids(input int n, input int budget);
        int c;
        c = 0;
        while (valid_cyc.size() < n && c < budget) begin
            @(posedge CLK);
            c++;
        end
        checkOutput("valid_timeout", LW'(valid_cyc.size() >= n), LW'(1));
    endtask

    task automatic resetModel();
        exp_lines.delete();
        k           = 0;
        exp_valid   = 1'b0;
        exp_overrun = 1'b0;
        last_line   = '0;
    endtask

    // Memory ack driver: tied high, every third request cycle, or random.
    // Modes 1 and 2 also throw acks at the responder while MEM_REQ is low.
    initial begin
        bus.MEM_ACK = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            case (ack_mode)
                0: bus.MEM_ACK = 1'b1;
                1: begin
                    if (bus.MEM_REQ) begin
                        bus.MEM_ACK = (wait_phase == 2);
                        wait_phase  = (wait_phase == 2) ? 0 : wait_phase + 1;
                    end else begin
                        bus.MEM_ACK = 1'($urandom_range(0, 1));
                        wait_phase  = 0;
                    end
                end
                default: bus.MEM_ACK = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Cycle-by-cycle comparison against the reference model, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge CLK);
            if (bus.L1_DATA_VALID === 1'b1) valid_cyc.push_back(cyc);
            if (!RST) begin
                mon_exp_req = (exp_lines.size() != 0) && !exp_valid;
                checkOutput("mem_req", LW'(bus.MEM_REQ), LW'(mon_exp_req));
                checkOutput("busy", LW'(bus.BUSY), LW'(exp_lines.size() != 0));
                checkOutput("overrun", LW'(bus.OVERRUN), LW'(exp_overrun));
                checkOutput("l1_valid", LW'(bus.L1_DATA_VALID), LW'(exp_valid));
                if (exp_valid && exp_lines.size() != 0) begin
                    exp_line = model_line(exp_lines[0]);
                    checkOutput("l1_data", bus.L1_DATA, exp_line);
                    last_line = exp_line;
                end else begin
                    checkOutput("l1_hold", bus.L1_DATA, last_line);
                end
                mon_next_valid = 1'b0;
                if (mon_exp_req) begin
                    checkOutput("mem_addr", LW'(bus.MEM_ADDR), LW'(tb_addr(exp_lines[0], k)));
                    if (bus.MEM_ACK) begin
                        if (k == BS - 1) begin
                            mon_next_valid = 1'b1;
                            k = 0;
                        end else begin
                            k++;
                        end
                    end
                end
                if (bus.L1_ADDR_VALID) begin
                    if (exp_lines.size() >= 2) exp_overrun = 1'b1;
                    else exp_lines.push_back(bus.L1_ADDR);
                end
                if (exp_valid) void'(exp_lines.pop_front());
                exp_valid = mon_next_valid;
            end
        end
    end

    initial begin
        int c0;
        logic [24:0] a;
        RST               = 1'b1;
        bus.L1_ADDR       = '0;
        bus.L1_ADDR_VALID = 1'b0;

        // Reset values
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("rst_l1_data", bus.L1_DATA, '0);
        checkOutput("rst_l1_valid", LW'(bus.L1_DATA_VALID), '0);
        checkOutput("rst_mem_addr", LW'(bus.MEM_ADDR), '0);
        checkOutput("rst_mem_req", LW'(bus.MEM_REQ), '0);
        checkOutput("rst_busy", LW'(bus.BUSY), '0);
        checkOutput("rst_overrun", LW'(bus.OVERRUN), '0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Single fill, ack tied high, data = word address
        $display("[TB] single fill");
        ack_mode = 0;
        valid_cyc.delete();
        applyStimulus(25'h000200);
        c0 = req_cyc;
        waitValids(1, 200);
        checkOutput("single_latency", LW'(valid_cyc[0] - c0), LW'(33));
        checkOutput("single_word0", LW'(bus.L1_DATA[31:0]), LW'(32'h0001_0000));
        checkOutput("single_word31", LW'(bus.L1_DATA[1023:992]), LW'(32'h0001_007C));
        repeat (3) @(posedge CLK);

        // Wait states: ack every third request cycle
        $display("[TB] wait states");
        ack_mode = 1;
        salt = $urandom;
        valid_cyc.delete();
        applyStimulus(25'($urandom));
        c0 = req_cyc;
        waitValids(1, 400);
        checkOutput("wait_latency", LW'(valid_cyc[0] - c0), LW'(1 + 3 * 32));
        repeat (3) @(posedge CLK);

        // Back-to-back: second request five cycles after the first
        $display("[TB] back-to-back");
        ack_mode = 0;
        valid_cyc.delete();
        applyStimulus(25'($urandom));
        c0 = req_cyc;
        repeat (3) @(posedge CLK);
        applyStimulus(25'($urandom));
        waitValids(2, 300);
        checkOutput("b2b_first", LW'(valid_cyc[0] - c0), LW'(33));
        checkOutput("b2b_spacing", LW'(valid_cyc[1] - valid_cyc[0]), LW'(33));
        repeat (3) @(posedge CLK);

        // Overrun: three requests inside one fill
        $display("[TB] overrun");
        checkOutput("ovr_before", LW'(bus.OVERRUN), '0);
        valid_cyc.delete();
        applyStimulus(25'($urandom));
        repeat (1) @(posedge CLK);
        applyStimulus(25'($urandom));
        repeat (1) @(posedge CLK);
        applyStimulus(25'($urandom));
        waitValids(2, 300);
        repeat (40) @(posedge CLK);
        checkOutput("ovr_lines", LW'(valid_cyc.size()), LW'(2));
        checkOutput("ovr_sticky", LW'(bus.OVERRUN), LW'(1));

        // Reset in the middle of a fill, at word 10
        $display("[TB] reset mid-fill");
        valid_cyc.delete();
        applyStimulus(25'($urandom));
        c0 = 0;
        while (k < 10 && c0 < 100) begin
            @(posedge CLK);
            #1;
            c0++;
        end
        checkOutput("mid_reached", LW'(k >= 10), LW'(1));
        RST = 1'b1;
        resetModel();
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("mid_l1_data", bus.L1_DATA, '0);
        checkOutput("mid_mem_addr", LW'(bus.MEM_ADDR), '0);
        checkOutput("mid_mem_req", LW'(bus.MEM_REQ), '0);
        checkOutput("mid_busy", LW'(bus.BUSY), '0);
        checkOutput("mid_overrun", LW'(bus.OVERRUN), '0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (40) @(posedge CLK);
        checkOutput("mid_no_valid", LW'(valid_cyc.size()), '0);
        applyStimulus(25'($urandom));
        c0 = req_cyc;
        waitValids(1, 200);
        checkOutput("mid_refill", LW'(valid_cyc[0] - c0), LW'(33));
        repeat (3) @(posedge CLK);

        // Request landing exactly in the DONE cycle, random acks
        $display("[TB] DONE collision");
        ack_mode = 2;
        salt = $urandom;
        valid_cyc.delete();
        applyStimulus(25'($urandom));
        for (int i = 0; i < 400; i++) begin
            @(posedge CLK);
            #1;
            if (exp_valid) break;
        end
        checkOutput("coll_found", LW'(exp_valid), LW'(1));
        a = 25'($urandom);
        bus.L1_ADDR       = a;
        bus.L1_ADDR_VALID = 1'b1;
        @(posedge CLK);
        #1;
        bus.L1_ADDR_VALID = 1'b0;
        waitValids(2, 600);
        checkOutput("coll_line", bus.L1_DATA, model_line(a));

        // Random request stream
        $display("[TB] random stream");
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 40)) @(posedge CLK);
            applyStimulus(25'($urandom));
        end
        c0 = 0;
        while (exp_lines.size() != 0 && c0 < 2000) begin
            @(posedge CLK);
            c0++;
        end
        checkOutput("drain", LW'(exp_lines.size()), '0);
        repeat (5) @(posedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
